// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and widths for the 4-bit CPU sequencer
package cpu_pkg;

    localparam int INSTR_W = 7;
    localparam int OPC_W   = 3;

    localparam logic [OPC_W-1:0] OP_NOP = 3'd0;
    localparam logic [OPC_W-1:0] OP_LDI = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_SUB = 3'd3;
    localparam logic [OPC_W-1:0] OP_AND = 3'd4;
    localparam logic [OPC_W-1:0] OP_OR  = 3'd5;
    localparam logic [OPC_W-1:0] OP_JZ  = 3'd6;
    localparam logic [OPC_W-1:0] OP_HLT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

    // Opcodes whose result lands in the accumulator.
    function automatic logic writes_acc(input logic [OPC_W-1:0] op);
        return (op >= OP_LDI) && (op <= OP_OR);
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - 3-to-8 one-hot decoder
// Ports: sel_i (opcode), onehot_o (bit sel_i set, all others clear).
module decoder_3to8
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0]      sel_i,
    output logic [(1<<OPC_W)-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - FETCH/DECODE/EXECUTE sequencer, PC owner and opcode decode
// Ports: clk, rst_n (sync, active-low); start (run request in IDLE/HALT);
//        instr (imem word at pc), zero (ALU accumulator-zero flag);
//        pc (imem address), operand (ir[3:0]), op_onehot (decoded opcode),
//        exec_en (execute strobe), acc_we (accumulator write), busy, halted.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         operand,
    output logic [7:0]         op_onehot,
    output logic               exec_en,
    output logic               acc_we,
    output logic               busy,
    output logic               halted
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [OPC_W-1:0]     opc;
    logic [7:0]           dec_onehot;
    logic                 in_dec_exec;

    assign opc = ir_q[6:4];

    decoder_3to8 u_dec (
        .sel_i    (opc),
        .onehot_o (dec_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = RESET_PC;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (opc == OP_HLT) begin
                    // PC stays on the HLT so the halt address is observable.
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if (opc == OP_JZ && zero) begin
                        pc_d = PC_W'(ir_q[3:0]);
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The decode is taken from the latched instruction and gated by the
    // registered state, so it is one-hot for all of DECODE and EXECUTE
    // and zero in every other state.
    assign in_dec_exec = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
    assign op_onehot   = dec_onehot & {8{in_dec_exec}};

    assign pc      = pc_q;
    assign operand = ir_q[3:0];
    assign exec_en = (state_q == ST_EXECUTE);
    assign acc_we  = exec_en && writes_acc(opc);
    assign busy    = (state_q == ST_FETCH) || in_dec_exec;
    assign halted  = (state_q == ST_HALT);

endmodule
